// File: rtl/cond_exec_stage.sv
// Conditional-execution stage: registers decoder controls for one cycle, evaluates the
// condition field against the NZCV register and gates the side-effect controls and flag writes.
module cond_exec_stage (
   input  logic       clk,
   input  logic       reset,
   input  logic       stall,
   input  logic       flush,
   input  logic       valid_in,
   input  logic [3:0] Cond,
   input  logic       PCS,
   input  logic       RegWrite,
   input  logic       MemWrite,
   input  logic [1:0] FlagW,
   input  logic [3:0] ALUFlags,
   output logic       PCSrc,
   output logic       RegWriteEx,
   output logic       MemWriteEx,
   output logic       CondEx,
   output logic [3:0] Flags
);

   logic       valid_reg;
   logic [3:0] cond_reg;
   logic       pcs_reg;
   logic       regw_reg;
   logic       memw_reg;
   logic [1:0] flagw_reg;
   logic [1:0] nz_reg;
   logic [1:0] cv_reg;
   logic       cond_pass;
   logic       flag_n, flag_z, flag_c, flag_v;

   assign Flags = {nz_reg, cv_reg};
   assign flag_n = nz_reg[1];
   assign flag_z = nz_reg[0];
   assign flag_c = cv_reg[1];
   assign flag_v = cv_reg[0];

   always_comb begin
      cond_pass = 1'b0;
      case (cond_reg)
         4'b0000: cond_pass = flag_z;
         4'b0001: cond_pass = !flag_z;
         4'b0010: cond_pass = flag_c;
         4'b0011: cond_pass = !flag_c;
         4'b0100: cond_pass = flag_n;
         4'b0101: cond_pass = !flag_n;
         4'b0110: cond_pass = flag_v;
         4'b0111: cond_pass = !flag_v;
         4'b1000: cond_pass = flag_c & !flag_z;
         4'b1001: cond_pass = !flag_c | flag_z;
         4'b1010: cond_pass = (flag_n == flag_v);
         4'b1011: cond_pass = (flag_n != flag_v);
         4'b1100: cond_pass = !flag_z & (flag_n == flag_v);
         4'b1101: cond_pass = flag_z | (flag_n != flag_v);
         4'b1110: cond_pass = 1'b1;
         default: cond_pass = 1'b0;
      endcase
   end

   assign CondEx     = valid_reg & cond_pass;
   assign PCSrc      = pcs_reg  & CondEx & !stall;
   assign RegWriteEx = regw_reg & CondEx & !stall;
   assign MemWriteEx = memw_reg & CondEx & !stall;

   // A taken branch squashes the instruction being captured on the same edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_reg <= 1'b0;
         cond_reg  <= 4'b0000;
         pcs_reg   <= 1'b0;
         regw_reg  <= 1'b0;
         memw_reg  <= 1'b0;
         flagw_reg <= 2'b00;
      end else if (!stall) begin
         if (flush || PCSrc) begin
            valid_reg <= 1'b0;
            cond_reg  <= 4'b0000;
            pcs_reg   <= 1'b0;
            regw_reg  <= 1'b0;
            memw_reg  <= 1'b0;
            flagw_reg <= 2'b00;
         end else begin
            valid_reg <= valid_in;
            cond_reg  <= Cond;
            pcs_reg   <= PCS;
            regw_reg  <= RegWrite;
            memw_reg  <= MemWrite;
            flagw_reg <= FlagW;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         nz_reg <= 2'b00;
         cv_reg <= 2'b00;
      end else if (!stall && CondEx) begin
         if (flagw_reg[1]) nz_reg <= ALUFlags[3:2];
         if (flagw_reg[0]) cv_reg <= ALUFlags[1:0];
      end
   end

endmodule

// File: tb/tb_cond_exec_stage.sv
// Randomized and directed bench for cond_exec_stage against an instruction-level reference model.
module tb_cond_exec_stage;

   logic       clk;
   logic       reset;
   logic       stall, flush, valid_in;
   logic [3:0] Cond;
   logic       PCS, RegWrite, MemWrite;
   logic [1:0] FlagW;
   logic [3:0] ALUFlags;
   logic       PCSrc, RegWriteEx, MemWriteEx, CondEx;
   logic [3:0] Flags;

   int n_checks = 0;
   int n_errors = 0;

   // reference model: the instruction sitting in the stage plus the NZCV register
   logic       m_valid, m_pcs, m_rw, m_mw;
   logic [3:0] m_cond, m_flags;
   logic [1:0] m_fw;

   // outputs observed during the most recent step
   logic       o_pc, o_rw, o_mw, o_cx;
   logic [3:0] o_flags;

   cond_exec_stage dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush), .valid_in(valid_in),
      .Cond(Cond), .PCS(PCS), .RegWrite(RegWrite), .MemWrite(MemWrite), .FlagW(FlagW),
      .ALUFlags(ALUFlags), .PCSrc(PCSrc), .RegWriteEx(RegWriteEx), .MemWriteEx(MemWriteEx),
      .CondEx(CondEx), .Flags(Flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end else begin
         $display("ok   %s: %h at %0t", tag, got, $time);
      end
   endtask

   // Condition pairs share a base test; the odd member is its inverse.
   function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cc, v, base;
      n = f[3]; z = f[2]; cc = f[1]; v = f[0];
      case (c[3:1])
         3'd0: base = z;
         3'd1: base = cc;
         3'd2: base = n;
         3'd3: base = v;
         3'd4: base = cc && !z;
         3'd5: base = (n == v);
         3'd6: base = !z && (n == v);
         default: base = 1'b1;
      endcase
      if (c == 4'hF) return 1'b0;
      return c[0] ? !base : base;
   endfunction

   task automatic model_clear();
      m_valid = 0; m_pcs = 0; m_rw = 0; m_mw = 0; m_cond = 0; m_fw = 0; m_flags = 0;
   endtask

   task automatic step(input logic sv, input logic fl, input logic vi, input logic [3:0] c,
                       input logic p, input logic rw, input logic mw,
                       input logic [1:0] fw, input logic [3:0] alu);
      logic e_cx, e_pc;
      stall = sv; flush = fl; valid_in = vi; Cond = c; PCS = p;
      RegWrite = rw; MemWrite = mw; FlagW = fw; ALUFlags = alu;
      #1;
      e_cx = m_valid && ref_cond(m_cond, m_flags);
      e_pc = m_pcs && e_cx && !sv;
      o_pc = PCSrc; o_rw = RegWriteEx; o_mw = MemWriteEx; o_cx = CondEx; o_flags = Flags;
      check("condex", {3'b0, CondEx}, {3'b0, e_cx});
      check("pcsrc", {3'b0, PCSrc}, {3'b0, e_pc});
      check("regwex", {3'b0, RegWriteEx}, {3'b0, m_rw && e_cx && !sv});
      check("memwex", {3'b0, MemWriteEx}, {3'b0, m_mw && e_cx && !sv});
      check("flags", Flags, m_flags);
      @(posedge clk);
      if (!sv) begin
         if (e_cx && m_fw[1]) m_flags[3:2] = alu[3:2];
         if (e_cx && m_fw[0]) m_flags[1:0] = alu[1:0];
         if (fl || e_pc) begin
            m_valid = 0; m_cond = 0; m_pcs = 0; m_rw = 0; m_mw = 0; m_fw = 0;
         end else begin
            m_valid = vi; m_cond = c; m_pcs = p; m_rw = rw; m_mw = mw; m_fw = fw;
         end
      end
      #2;
   endtask

   task automatic idle(input logic [3:0] alu);
      step(0, 0, 0, 4'h0, 0, 0, 0, 2'b00, alu);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      #1;
      check("rst_condex", {3'b0, CondEx}, 4'h0);
      check("rst_pcsrc", {3'b0, PCSrc}, 4'h0);
      check("rst_regwex", {3'b0, RegWriteEx}, 4'h0);
      check("rst_memwex", {3'b0, MemWriteEx}, 4'h0);
      check("rst_flags", Flags, 4'h0);
      model_clear();
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
   endtask

   initial begin
      reset = 1'b0;
      stall = 0; flush = 0; valid_in = 0; Cond = 0; PCS = 0;
      RegWrite = 0; MemWrite = 0; FlagW = 0; ALUFlags = 0;
      model_clear();
      @(posedge clk); #2;
      do_reset();

      // AL flag setter with register write
      step(0, 0, 1, 4'hE, 0, 1, 0, 2'b11, 4'b0100);
      idle(4'b0100);
      check("s28_regwex", {3'b0, o_rw}, 4'h1);
      check("s28_condex", {3'b0, o_cx}, 4'h1);
      idle(4'b0000);
      check("s28_flags", o_flags, 4'b0100);

      // EQ passes, NE fails and must not touch flags
      step(0, 0, 1, 4'h0, 0, 0, 1, 2'b00, 4'b0000);
      idle(4'b0000);
      check("s29_eq_memwex", {3'b0, o_mw}, 4'h1);
      step(0, 0, 1, 4'h1, 0, 0, 1, 2'b11, 4'b1111);
      idle(4'b1111);
      check("s29_ne_memwex", {3'b0, o_mw}, 4'h0);
      idle(4'b1111);
      check("s29_ne_flags", o_flags, 4'b0100);

      // taken branch kills the following instruction
      step(0, 0, 1, 4'hE, 1, 0, 0, 2'b00, 4'b0000);
      step(0, 0, 1, 4'hE, 0, 1, 0, 2'b00, 4'b0000);
      check("s30_pcsrc", {3'b0, o_pc}, 4'h1);
      idle(4'b0000);
      check("s30_killed_regwex", {3'b0, o_rw}, 4'h0);
      check("s30_killed_condex", {3'b0, o_cx}, 4'h0);

      // flag setter held by a three-cycle stall
      step(0, 0, 1, 4'hE, 0, 1, 0, 2'b11, 4'b1000);
      for (int i = 0; i < 3; i++) begin
         step(1, 0, 0, 4'h0, 0, 0, 0, 2'b00, 4'b1000);
         check("s31_stalled_regwex", {3'b0, o_rw}, 4'h0);
         check("s31_stalled_flags", o_flags, 4'b0100);
      end
      idle(4'b1000);
      check("s31_release_regwex", {3'b0, o_rw}, 4'h1);
      idle(4'b0000);
      check("s31_flags_once", o_flags, 4'b1000);
      check("s31_no_repeat", {3'b0, o_rw}, 4'h0);

      // stall beats flush, then flush alone bubbles
      step(0, 0, 1, 4'hE, 0, 1, 0, 2'b00, 4'b0000);
      step(1, 1, 0, 4'h0, 0, 0, 0, 2'b00, 4'b0000);
      idle(4'b0000);
      check("s33_held_regwex", {3'b0, o_rw}, 4'h1);
      step(0, 1, 1, 4'hE, 0, 1, 1, 2'b11, 4'b1111);
      idle(4'b0000);
      check("s33_flush_regwex", {3'b0, o_rw}, 4'h0);
      check("s33_flush_condex", {3'b0, o_cx}, 4'h0);

      // every condition against every flag value
      for (int f = 0; f < 16; f++) begin
         step(0, 0, 1, 4'hE, 0, 0, 0, 2'b11, 4'(f));
         for (int c = 0; c < 16; c++)
            step(0, 0, 1, 4'(c), 0, 0, 0, 2'b00, 4'h0);
         idle(4'h0);
         check("s32_nv_condex", {3'b0, o_cx}, 4'h0);
      end

      // reset mid-instruction discards it
      step(0, 0, 1, 4'hE, 0, 1, 0, 2'b11, 4'b1111);
      do_reset();
      idle(4'b1111);
      check("s27_flags_after_reset", o_flags, 4'h0);
      check("s27_regwex_after_reset", {3'b0, o_rw}, 4'h0);

      for (int i = 0; i < 500; i++) begin
         step($urandom_range(3) == 0, $urandom_range(7) == 0, 1'($urandom),
              4'($urandom), 1'($urandom_range(3) == 0), 1'($urandom), 1'($urandom),
              2'($urandom), 4'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
